// File: rtl/ifid_queue_pkg.sv
// Shared fetch/decode pipeline definitions: bubble instruction, IF/ID entry
// layout and pointer-width helper.
package ifid_queue_pkg;

  localparam int PKG_XLEN = 32;

  // RISC-V canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pcplus4;
    logic [PKG_XLEN-1:0] instr;
  } ifid_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifid_queue_chk.sv
// Occupancy and flag-consistency properties for ifid_queue.
module ifid_queue_chk #(
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   in_ready,
  input logic                   out_valid,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH))
    else $error("ifid_queue_chk: count %0d exceeds DEPTH", count);

  a_out_valid: assert property (@(posedge clk) disable iff (!reset)
    out_valid == (count != CW'(0)))
    else $error("ifid_queue_chk: out_valid inconsistent with count %0d", count);

  a_in_ready: assert property (@(posedge clk) disable iff (!reset)
    in_ready == (count != CW'(DEPTH)))
    else $error("ifid_queue_chk: in_ready inconsistent with count %0d", count);

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: circular buffer with first-word fall-through and a
// NOP bubble on the output whenever empty.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = PKG_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pcplus4,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pcplus4,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_CNT = {CW{1'b0}};

  ifid_entry_t       mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_s;
  logic              pop_s;
  ifid_entry_t       head_s;

  // Ready/valid derive only from registered occupancy, never from out_ready.
  always_comb begin
    in_ready  = (count_r != FULL_CNT);
    out_valid = (count_r != EMPTY_CNT);
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
    count     = count_r;
  end

  // Head presentation, substituting a zero-PC NOP bubble when empty.
  always_comb begin
    head_s      = mem_r[rd_ptr_r];
    out_pc      = {XLEN{1'b0}};
    out_pcplus4 = {XLEN{1'b0}};
    out_instr   = XLEN'(NOP_INSTR);
    if (out_valid) begin
      out_pc      = head_s.pc;
      out_pcplus4 = head_s.pcplus4;
      out_instr   = head_s.instr;
    end else begin
      out_pc      = {XLEN{1'b0}};
      out_pcplus4 = {XLEN{1'b0}};
      out_instr   = XLEN'(NOP_INSTR);
    end
  end

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= EMPTY_CNT;
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= EMPTY_CNT;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
          count_r  <= count_r + CW'(1);
        end
        2'b01: begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
          count_r  <= count_r - CW'(1);
        end
        2'b11: begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        default: begin
          wr_ptr_r <= wr_ptr_r;
          rd_ptr_r <= rd_ptr_r;
          count_r  <= count_r;
        end
      endcase
    end
  end

  // Entry storage; contents are left stale across flush and reset.
  always_ff @(posedge clk) begin
    if (reset && !flush && push_s) begin
      mem_r[wr_ptr_r] <= ifid_entry_t'{pc: in_pc, pcplus4: in_pcplus4, instr: in_instr};
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_ifid_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pcplus4;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcplus4;
  logic [XLEN-1:0] out_instr;
  logic [1:0]      count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] ins;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  ifid_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr),
    .count(count)
  );

  ifid_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk(clk), .reset(reset), .in_ready(in_ready),
    .out_valid(out_valid), .count(count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0000;
  endfunction

  // Drive one cycle (inputs set just after negedge), advance the model, return at next negedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic f, input logic rst);
    bit acc_push, acc_pop;
    ent_t e;
    in_valid   = v;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
    in_instr   = instr_of(pc);
    out_ready  = rdy;
    flush      = f;
    reset      = rst;
    acc_push = v && (mq.size() < DEPTH);
    acc_pop  = rdy && (mq.size() > 0);
    e.pc = pc; e.p4 = pc + 32'd4; e.ins = instr_of(pc);
    @(posedge clk);
    if (!rst || f) begin
      mq.delete();
    end else begin
      if (acc_pop) void'(mq.pop_front());
      if (acc_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1 || count !== 2'd0) begin errors++; $display("FAIL idle_after_reset got ready=%0b count=%0d exp ready=1 count=0", in_ready, count); end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pcs[i], 1'b1, 1'b0, 1'b1);
      checks++; if (out_pc !== pcs[i] || out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_pc[%0d] got=%h v=%0b exp=%h v=1", i, out_pc, out_valid, pcs[i]); end
      checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_count[%0d] got count=%0d ready=%0b exp count=1 ready=1", i, count, in_ready); end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got count=%0d v=%0b exp 0/0", count, out_valid); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h14, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got count=%0d ready=%0b exp count=2 ready=0", count, in_ready); end
    cycle(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 2'd2 || out_pc !== 32'h10) begin errors++; $display("FAIL bp_ignored_push got count=%0d pc=%h exp count=2 pc=10", count, out_pc); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checks++; if (out_pc !== 32'h14 || out_pcplus4 !== 32'h18) begin errors++; $display("FAIL bp_second got pc=%h p4=%h exp pc=14 p4=18", out_pc, out_pcplus4); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || count !== 2'd0) begin errors++; $display("FAIL bp_no_18 got v=%0b pc=%h count=%0d exp v=0 pc=0 count=0", out_valid, out_pc, count); end
  endtask

  task automatic test_full_pop();
    cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h28, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_count got count=%0d ready=%0b exp count=1 ready=1", count, in_ready); end
    checks++; if (out_pc !== 32'h24 || out_instr !== instr_of(32'h24)) begin errors++; $display("FAIL fullpop_head got pc=%h ins=%h exp pc=24 ins=%h", out_pc, out_instr, instr_of(32'h24)); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_no_28 got count=%0d v=%0b exp 0/0", count, out_valid); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h34, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got count=%0d v=%0b ready=%0b exp 0/0/1", count, out_valid, in_ready); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL flush_nop got=%h exp=%h", out_instr, NOP); end
    cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    checks++; if (out_pc !== 32'h80 || out_pcplus4 !== 32'h84 || count !== 2'd1) begin errors++; $display("FAIL flush_refill got pc=%h p4=%h count=%0d exp 80/84/1", out_pc, out_pcplus4, count); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h54, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h58, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_pcplus4 !== 32'h0) begin errors++; $display("FAIL midreset_state got count=%0d v=%0b pc=%h p4=%h exp 0/0/0/0", count, out_valid, out_pc, out_pcplus4); end
    cycle(1'b1, 32'h60, 1'b0, 1'b0, 1'b1);
    checks++; if (out_pc !== 32'h60 || count !== 2'd1) begin errors++; $display("FAIL midreset_push1 got pc=%h count=%0d exp 60/1", out_pc, count); end
    cycle(1'b1, 32'h64, 1'b1, 1'b0, 1'b1);
    checks++; if (out_pc !== 32'h64 || count !== 2'd1) begin errors++; $display("FAIL midreset_push2 got pc=%h count=%0d exp 64/1", out_pc, count); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] epc, ep4, eins;
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom() & 32'hffff_fffc,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 49) != 0));
      if (mq.size() > 0) begin
        epc = mq[0].pc; ep4 = mq[0].p4; eins = mq[0].ins;
      end else begin
        epc = 32'h0; ep4 = 32'h0; eins = NOP;
      end
      checks++; if (count !== 2'(mq.size()) || in_ready !== (mq.size() != DEPTH) || out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_flags[%0d] got count=%0d ready=%0b v=%0b exp count=%0d", i, count, in_ready, out_valid, mq.size());
      end
      checks++; if (out_pc !== epc || out_pcplus4 !== ep4 || out_instr !== eins) begin
        errors++; $display("FAIL rand_head[%0d] got pc=%h p4=%h ins=%h exp pc=%h p4=%h ins=%h", i, out_pc, out_pcplus4, out_instr, epc, ep4, eins);
      end
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_pcplus4 = 32'h0; in_instr = 32'h0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
